// File: rtl/uart_tx_sched_if.sv
// Bus bundle between the load/store unit, the UART TX scheduler and the UART
// transmitter. The scheduler takes the slave view; whoever drives the
// pipeline and models the transmitter takes the master view.
interface uart_tx_sched_if;
    logic        st_valid_i;
    logic [7:0]  st_data_i;
    logic        ld_valid_i;
    logic        stall_o;
    logic [31:0] status_o;
    logic        tx_start_o;
    logic [7:0]  tx_byte_o;
    logic        tx_busy_i;
    logic        tx_done_i;

    modport master (
        output st_valid_i, st_data_i, ld_valid_i, tx_busy_i, tx_done_i,
        input  stall_o, status_o, tx_start_o, tx_byte_o
    );

    modport slave (
        input  st_valid_i, st_data_i, ld_valid_i, tx_busy_i, tx_done_i,
        output stall_o, status_o, tx_start_o, tx_byte_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers UART-window store bytes in a small FIFO and
// feeds them one at a time to the transmitter over a start/done handshake.
// UART-window loads return a status word. Optional build macro
// UART_TX_TIMEOUT_EN adds a WAIT_DONE watchdog with a sticky error flag.
module uart_tx_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input logic            clk,
    input logic            rst_n,
    uart_tx_sched_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       tx_byte;
    logic             full, empty, push, pop, tx_start, busy;
    logic             tmo_hit, err_flag;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO refuses the store even if the FSM pops this same cycle.
    assign push  = bus.st_valid_i & ~full;
    assign busy  = (state != IDLE) | ~empty;

    assign bus.stall_o    = bus.st_valid_i & full;
    assign bus.tx_start_o = tx_start;
    assign bus.tx_byte_o  = tx_byte;
    assign bus.status_o   = bus.ld_valid_i
                          ? {23'h0, 5'(count), err_flag, empty, full, busy}
                          : 32'h0;

    // State register for the drain FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM: pop in IDLE, start when the transmitter is free, wait for done.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (!bus.tx_busy_i) begin
                    tx_start  = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_i || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.st_data_i;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte handed to the transmitter, held from the pop until the next pop.
    always_ff @(posedge clk) begin
        if (!rst_n)   tx_byte <= 8'h00;
        else if (pop) tx_byte <= fifo_mem[rd_ptr];
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT-th consecutive WAIT_DONE cycle without a done pulse.
    assign tmo_hit = (state == WAIT_DONE) && !bus.tx_done_i
                  && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Watchdog counter and sticky error flag; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == WAIT_DONE && state_nxt == WAIT_DONE) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                                               tmo_cnt <= '0;
            if (tmo_hit) err_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign err_flag = 1'b0;

    // TIMEOUT only matters with the watchdog built in; legal range is >= 1.
    if (TIMEOUT < 1) begin : g_timeout_out_of_range
    end
`endif
endmodule
